ltc2387_acq_ctrl: RTL and testbench
===================================

Name: ltc2387_acq_ctrl

Overview:
Acquisition sequencer for the LTC2387-18 front end, in the sys_clk_int domain. Issues periodic single-cycle conversion triggers to the ADC interface (trig_int) and collects the reconstructed samples (adc_data_out/adc_data_valid). Runs finite bursts or continuous capture and forwards samples on a valid/ready stream with end-of-burst marking. Detects missing samples (timeout) and stream back-pressure loss (overflow).

Parameters:
ADC_WIDTH, 18, sample width
PERIOD_WIDTH, 16, width of the trigger period register
COUNT_WIDTH, 16, width of burst length and sample counter
MIN_PERIOD, 8, smallest legal trigger period in cycles; smaller requests are clamped
TIMEOUT_CYCLES, 64, maximum cycles from trig_int to adc_data_valid

Ports:
sys_clk_int  in  1  system clock
reset_int  in  1  asynchronous, active-high reset
start  in  1  one-cycle start request
stop  in  1  one-cycle stop request
continuous  in  1  1 = run until stop; 0 = burst of burst_len samples
period  in  PERIOD_WIDTH  cycles between triggers
burst_len  in  COUNT_WIDTH  samples per burst
trig_int  out  1  one-cycle conversion request to the ADC interface
adc_data_in  in  ADC_WIDTH  sample from the ADC interface
adc_data_in_valid  in  1  sample strobe from the ADC interface
m_data  out  ADC_WIDTH  output sample
m_valid  out  1  output valid
m_ready  in  1  downstream ready
m_last  out  1  final sample of a burst or stop
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at the end of a run
sample_cnt  out  COUNT_WIDTH  samples received in the current run
err_timeout  out  1  sticky timeout flag
err_overflow  out  1  sticky overflow flag
clear_err  in  1  clears both sticky flags

Behaviour:
- Reset: clears all state. State = IDLE. trig_int, m_valid, m_last, busy, done, err flags = 0. m_data = 0. sample_cnt = 0.
- period, burst_len and continuous are latched on an accepted start. The effective period is max(period, MIN_PERIOD).
- States:
  - IDLE: start accepted -> WAIT with the period counter at 0. sample_cnt = 0. start while busy is ignored.
  - WAIT: the period counter decrements to 0 and saturates there. When the counter is 0, pulse trig_int for one cycle, reload the counter with eff_period-1, and go to CONV.
  - CONV: the timeout counter runs and the period counter keeps decrementing.
    - On adc_data_in_valid: capture the sample and increment sample_cnt (wraps modulo 2^COUNT_WIDTH). If this is the final sample (burst mode and sample_cnt+1 == burst_len) or stop is pending, go to DRAIN. Otherwise go to WAIT.
    - Timeout expires: set err_timeout and go to DRAIN. No sample is pushed and m_last is not set.
  - DRAIN: wait for m_valid == 0, then pulse done and go to IDLE.
- Timing: start in cycle N gives trig_int in cycle N+1. Steady-state trigger spacing is exactly eff_period cycles. If data arrives after the counter has already reached 0, the next trig_int occurs the cycle after WAIT is entered.
- Stop:
  - In WAIT: go to DRAIN immediately; no further trigger is issued.
  - In CONV: recorded as pending. The outstanding sample is still collected and flagged m_last.
  - Start and stop in the same cycle: stop wins.
- Burst mode with burst_len == 0: start goes straight to DRAIN, then done. No trig_int is issued.
- Output register (one entry):
  - A sample loads m_data and sets m_valid the cycle after adc_data_in_valid.
  - m_valid stays high until m_valid && m_ready.
  - A new sample arriving while m_valid && !m_ready is dropped and sets err_overflow. The dropped sample is still counted.
- adc_data_in_valid outside CONV is ignored: not counted, no error.
- clear_err clears both flags; a simultaneous set wins.
- trig_int, done and m_* are registered outputs.

Decomposition:
- Shared package ltc2387_pkg holds:
  - state enum (IDLE, WAIT, CONV, DRAIN)
  - ADC_WIDTH constant
  - MIN_PERIOD and TIMEOUT_CYCLES defaults
- One natural sub-module, ltc2387_out_reg: the one-entry valid/ready output register with overflow detection.
- Counters and FSM stay in the top level.

Test Plan:
1. Burst mode, period=10, burst_len=4, data returned 3 cycles after each trig, m_ready=1 -> trig_int at cycles 1,11,21,31. Four m_valid beats, m_last on the 4th. done one cycle after the last beat drains. sample_cnt=4.
2. period=3 -> clamped; trig_int spacing is 8 cycles.
3. ADC never responds, TIMEOUT_CYCLES=64 -> err_timeout set 64 cycles after trig_int. done pulses, busy drops, no m_valid. clear_err clears the flag.
4. Continuous mode, m_ready held 0, two samples arrive -> first sample held in m_data, second dropped, err_overflow=1, sample_cnt=2.
5. Continuous mode, stop asserted 2 cycles after a trig_int -> that sample is delivered with m_last=1, no further trig_int, then done.
6. reset_int asserted in CONV -> all outputs return to reset values in that cycle (asynchronous reset). A later adc_data_in_valid is ignored.

Source files
------------

// File: rtl/ltc2387_pkg.sv
// Shared state encoding and default sizing for the LTC2387 acquisition sequencer.
package ltc2387_pkg;

   localparam int ADC_WIDTH_DEF      = 18;
   localparam int MIN_PERIOD_DEF     = 8;
   localparam int TIMEOUT_CYCLES_DEF = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CONV  = 2'd2,
      DRAIN = 2'd3
   } acq_state_t;

endpackage

// File: rtl/ltc2387_out_reg.sv
// One-entry valid/ready output register; a load that finds the entry still
// occupied and not being consumed is dropped and flagged as an overflow.
module ltc2387_out_reg
   import ltc2387_pkg::*;
#(
   parameter int WIDTH = ADC_WIDTH_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_last,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_last,
   output logic             o_overflow
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_last;
   logic             w_blocked;

   assign w_blocked  = r_valid & ~i_ready;
   assign o_overflow = i_load & w_blocked;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else if (i_load && !w_blocked) begin
         // A handshake in the same cycle frees the entry for the new sample.
         r_data  <= i_data;
         r_valid <= 1'b1;
         r_last  <= i_last;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_last  = r_last;

endmodule

// File: rtl/ltc2387_acq_ctrl.sv
// Acquisition sequencer: periodic ADC triggers, sample collection, burst or
// continuous runs, stream output with end marking, timeout/overflow flags.
module ltc2387_acq_ctrl
   import ltc2387_pkg::*;
#(
   parameter int ADC_WIDTH      = ADC_WIDTH_DEF,
   parameter int PERIOD_WIDTH   = 16,
   parameter int COUNT_WIDTH    = 16,
   parameter int MIN_PERIOD     = MIN_PERIOD_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                    sys_clk_int,
   input  logic                    reset_int,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    continuous,
   input  logic [PERIOD_WIDTH-1:0] period,
   input  logic [COUNT_WIDTH-1:0]  burst_len,
   output logic                    trig_int,
   input  logic [ADC_WIDTH-1:0]    adc_data_in,
   input  logic                    adc_data_in_valid,
   output logic [ADC_WIDTH-1:0]    m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_last,
   output logic                    busy,
   output logic                    done,
   output logic [COUNT_WIDTH-1:0]  sample_cnt,
   output logic                    err_timeout,
   output logic                    err_overflow,
   input  logic                    clear_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   acq_state_t              r_state;
   acq_state_t              w_state_nxt;
   logic [PERIOD_WIDTH-1:0] r_period;
   logic [PERIOD_WIDTH-1:0] r_pcnt;
   logic [PERIOD_WIDTH-1:0] w_eff_in;
   logic [PERIOD_WIDTH-1:0] w_reload;
   logic [COUNT_WIDTH-1:0]  r_burst_len;
   logic [COUNT_WIDTH-1:0]  r_sample_cnt;
   logic [COUNT_WIDTH-1:0]  w_cnt_inc;
   logic [TW-1:0]           r_tcnt;
   logic                    r_cont;
   logic                    r_stop_pend;
   logic                    r_trig;
   logic                    r_done;
   logic                    r_err_to;
   logic                    r_err_ovf;
   logic                    w_accept;
   logic                    w_fire;
   logic                    w_capture;
   logic                    w_final;
   logic                    w_timeout;
   logic                    w_done_nxt;
   logic                    w_ovf;

   assign w_eff_in  = (period < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD) : period;
   assign w_reload  = w_accept ? w_eff_in : r_period;
   assign w_cnt_inc = r_sample_cnt + COUNT_WIDTH'(1);

   always_ff @(posedge sys_clk_int or posedge reset_int) begin
      if (reset_int) r_state <= IDLE;
      else           r_state <= w_state_nxt;
   end

   // An accepted start fires the first trigger directly: the period counter
   // is conceptually 0 on entry to WAIT, so WAIT would fire immediately.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_fire      = 1'b0;
      w_capture   = 1'b0;
      w_final     = 1'b0;
      w_timeout   = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !stop) begin
               w_accept = 1'b1;
               if (!continuous && burst_len == '0) begin
                  w_state_nxt = DRAIN;
               end else begin
                  w_fire      = 1'b1;
                  w_state_nxt = CONV;
               end
            end
         end
         WAIT: begin
            if (stop) begin
               w_state_nxt = DRAIN;
            end else if (r_pcnt == '0) begin
               w_fire      = 1'b1;
               w_state_nxt = CONV;
            end
         end
         CONV: begin
            if (adc_data_in_valid) begin
               w_capture   = 1'b1;
               w_final     = (!r_cont && w_cnt_inc == r_burst_len) || r_stop_pend || stop;
               w_state_nxt = w_final ? DRAIN : WAIT;
            end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
               w_timeout   = 1'b1;
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!m_valid) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_int or posedge reset_int) begin
      if (reset_int) begin
         r_period     <= '0;
         r_pcnt       <= '0;
         r_burst_len  <= '0;
         r_sample_cnt <= '0;
         r_tcnt       <= '0;
         r_cont       <= 1'b0;
         r_stop_pend  <= 1'b0;
         r_trig       <= 1'b0;
         r_done       <= 1'b0;
         r_err_to     <= 1'b0;
         r_err_ovf    <= 1'b0;
      end else begin
         r_trig <= w_fire;
         r_done <= w_done_nxt;
         if (w_accept) begin
            r_period     <= w_eff_in;
            r_burst_len  <= burst_len;
            r_cont       <= continuous;
            r_sample_cnt <= '0;
            r_stop_pend  <= 1'b0;
         end
         if (w_fire) begin
            r_pcnt <= w_reload - PERIOD_WIDTH'(1);
            r_tcnt <= '0;
         end else begin
            if (r_pcnt != '0)     r_pcnt <= r_pcnt - PERIOD_WIDTH'(1);
            if (r_state == CONV)  r_tcnt <= r_tcnt + TW'(1);
         end
         if (w_capture)               r_sample_cnt <= w_cnt_inc;
         if (r_state == CONV && stop) r_stop_pend  <= 1'b1;
         r_err_to  <= w_timeout | (r_err_to & ~clear_err);
         r_err_ovf <= w_ovf | (r_err_ovf & ~clear_err);
      end
   end

   ltc2387_out_reg #(
      .WIDTH (ADC_WIDTH)
   ) u_out_reg (
      .i_clk      (sys_clk_int),
      .i_rst      (reset_int),
      .i_load     (w_capture),
      .i_data     (adc_data_in),
      .i_last     (w_final),
      .i_ready    (m_ready),
      .o_data     (m_data),
      .o_valid    (m_valid),
      .o_last     (m_last),
      .o_overflow (w_ovf)
   );

   assign trig_int     = r_trig;
   assign done         = r_done;
   assign busy         = (r_state != IDLE);
   assign sample_cnt   = r_sample_cnt;
   assign err_timeout  = r_err_to;
   assign err_overflow = r_err_ovf;

endmodule

// File: tb/tb_ltc2387_acq_ctrl.sv
// Bench for ltc2387_acq_ctrl: table of run scenarios with an ADC responder
// and output scoreboard, plus hand sequences for reset, overflow and stop.
module tb_ltc2387_acq_ctrl;

   localparam int AW = 18;
   localparam int PW = 16;
   localparam int CW = 16;
   localparam int TO = 64;
   localparam int NV = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          continuous = 1'b0;
   logic [PW-1:0] period = '0;
   logic [CW-1:0] burst_len = '0;
   logic          trig_int;
   logic [AW-1:0] adc_data_in = '0;
   logic          adc_data_in_valid = 1'b0;
   logic [AW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic          m_last;
   logic          busy;
   logic          done;
   logic [CW-1:0] sample_cnt;
   logic          err_timeout;
   logic          err_overflow;
   logic          clear_err = 1'b0;

   always #5 clk = ~clk;

   ltc2387_acq_ctrl dut (
      .sys_clk_int       (clk),
      .reset_int         (rst),
      .start             (start),
      .stop              (stop),
      .continuous        (continuous),
      .period            (period),
      .burst_len         (burst_len),
      .trig_int          (trig_int),
      .adc_data_in       (adc_data_in),
      .adc_data_in_valid (adc_data_in_valid),
      .m_data            (m_data),
      .m_valid           (m_valid),
      .m_ready           (m_ready),
      .m_last            (m_last),
      .busy              (busy),
      .done              (done),
      .sample_cnt        (sample_cnt),
      .err_timeout       (err_timeout),
      .err_overflow      (err_overflow),
      .clear_err         (clear_err)
   );

   typedef struct {
      logic [AW-1:0] data;
      logic          last;
   } exp_t;

   typedef struct {
      int per;
      int blen;
      bit cont;
      int lat;        // trig->valid cycles, 0 = ADC never answers
      int stop_trig;  // index of trigger after which stop is driven, -1 = none
      int stop_dly;
      int exp_trig;
      int exp_space;
      int exp_cnt;
      bit exp_to;
      int exp_gap;    // cycles from last output beat to done, -1 = skip
   } vec_t;

   exp_t sb[$];
   int   tq[$];
   vec_t vt[NV];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_cyc, done_cyc, last_beat, to_cyc;
   bit   finished;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic run(input vec_t v, input bit rdy, input int budget);
      int            adc_due;
      int            stop_cyc;
      int            nsamp;
      bit            stop_seen;
      logic [AW-1:0] d;
      exp_t          e;
      tq.delete();
      sb.delete();
      done_cyc  = -1;
      last_beat = -1;
      to_cyc    = -1;
      finished  = 1'b0;
      adc_due   = -1;
      stop_cyc  = -1;
      nsamp     = 0;
      stop_seen = 1'b0;
      period     = PW'(v.per);
      burst_len  = CW'(v.blen);
      continuous = v.cont;
      m_ready    = rdy;
      start      = 1'b1;
      start_cyc  = cyc;
      for (int k = 0; k < budget; k++) begin
         tick();
         start = 1'b0;
         stop = 1'b0;
         adc_data_in_valid = 1'b0;
         if (trig_int) begin
            tq.push_back(cyc);
            if (v.lat > 0) adc_due = cyc + v.lat;
            if (v.stop_trig == tq.size() - 1) stop_cyc = cyc + v.stop_dly;
         end
         if (err_timeout && to_cyc < 0) to_cyc = cyc;
         if (done) begin
            done_cyc = cyc;
            finished = 1'b1;
            break;
         end
         if (cyc == stop_cyc) begin
            stop = 1'b1;
            stop_seen = 1'b1;
         end
         if (cyc == adc_due) begin
            d = AW'($urandom);
            adc_data_in = d;
            adc_data_in_valid = 1'b1;
            nsamp++;
            if (rdy || sb.size() == 0) begin
               e.data = d;
               e.last = (!v.cont && nsamp == v.blen) || stop_seen;
               sb.push_back(e);
            end
         end
         if (m_valid && m_ready) begin
            last_beat = cyc;
            if (sb.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("beat_data", m_data, e.data);
               chk("beat_last", m_last, e.last);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int exp_cnt_last;
      //        per blen cont lat stp dly trig space cnt to gap
      vt[0] = '{10,  4, 1'b0,  3, -1, 0,  4, 10,  4, 1'b0,  2};
      vt[1] = '{ 3,  3, 1'b0,  2, -1, 0,  3,  8,  3, 1'b0,  2};
      vt[2] = '{20,  2, 1'b0, 30, -1, 0,  2, 32,  2, 1'b0,  2};
      vt[3] = '{ 9,  0, 1'b0,  3, -1, 0,  0,  0,  0, 1'b0, -1};
      vt[4] = '{12,  0, 1'b1,  5,  1, 2,  2, 12,  2, 1'b0,  2};
      vt[5] = '{10,  2, 1'b0,  0, -1, 0,  1,  0,  0, 1'b1, -1};
      vt[6] = '{ 8,  3, 1'b0,  6, -1, 0,  3,  8,  3, 1'b0,  2};
      vt[7] = '{ 8,  3, 1'b0,  7, -1, 0,  3,  9,  3, 1'b0,  2};
      vt[8] = '{12,  0, 1'b1,  3,  0, 6,  1, 12,  1, 1'b0,  4};
      vt[9] = '{10,  1, 1'b0,  4, -1, 0,  1, 10,  1, 1'b0,  2};

      tick();
      tick();
      chk("rst_trig", trig_int, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mvalid", m_valid, 0);
      chk("rst_mlast", m_last, 0);
      chk("rst_mdata", m_data, 0);
      chk("rst_cnt", sample_cnt, 0);
      chk("rst_errs", {err_timeout, err_overflow}, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < NV; i++) begin
         run(vt[i], 1'b1, 400);
         chk($sformatf("c%0d_finished", i), finished, 1);
         chk($sformatf("c%0d_ntrig", i), tq.size(), vt[i].exp_trig);
         if (tq.size() > 0) chk($sformatf("c%0d_first_trig", i), tq[0] - start_cyc, 1);
         for (int j = 1; j < tq.size(); j++)
            chk($sformatf("c%0d_spacing%0d", i, j), tq[j] - tq[j-1], vt[i].exp_space);
         chk($sformatf("c%0d_sample_cnt", i), sample_cnt, vt[i].exp_cnt);
         chk($sformatf("c%0d_busy_at_done", i), busy, 0);
         chk($sformatf("c%0d_err_timeout", i), err_timeout, vt[i].exp_to);
         chk($sformatf("c%0d_sb_empty", i), sb.size(), 0);
         if (vt[i].exp_gap >= 0)
            chk($sformatf("c%0d_done_gap", i), done_cyc - last_beat, vt[i].exp_gap);
         if (vt[i].blen == 0 && !vt[i].cont)
            chk($sformatf("c%0d_empty_done", i), done_cyc - start_cyc, 2);
         if (vt[i].exp_to) begin
            chk($sformatf("c%0d_timeout_delay", i), to_cyc - tq[tq.size()-1], TO);
            chk($sformatf("c%0d_no_mvalid", i), last_beat, -1);
            clear_err = 1'b1;
            tick();
            clear_err = 1'b0;
            chk($sformatf("c%0d_clear_err", i), err_timeout, 0);
         end
         tick();
         tick();
      end
      exp_cnt_last = vt[NV-1].exp_cnt;

      // Sample strobe while idle is ignored.
      adc_data_in = 18'h2AAAA;
      adc_data_in_valid = 1'b1;
      tick();
      adc_data_in_valid = 1'b0;
      tick();
      chk("idle_valid_cnt", sample_cnt, exp_cnt_last);
      chk("idle_valid_mvalid", m_valid, 0);
      chk("idle_valid_errs", {err_timeout, err_overflow}, 0);

      // Start and stop together: stop wins.
      period = 10;
      burst_len = 2;
      continuous = 1'b0;
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      chk("start_stop_busy", busy, 0);
      chk("start_stop_trig", trig_int, 0);
      tick();
      tick();

      // Back-pressure: second sample dropped, first held.
      vt[0] = '{10, 0, 1'b1, 3, -1, 0, 0, 0, 0, 1'b0, -1};
      run(vt[0], 1'b0, 20);
      chk("ovf_running", finished, 0);
      chk("ovf_ntrig", tq.size(), 2);
      chk("ovf_mvalid", m_valid, 1);
      chk("ovf_mdata", m_data, sb[0].data);
      chk("ovf_mlast", m_last, 0);
      chk("ovf_flag", err_overflow, 1);
      chk("ovf_cnt", sample_cnt, 2);

      // Asynchronous reset while converting.
      tick();
      chk("pre_rst_trig", trig_int, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_trig", trig_int, 0);
      chk("arst_busy", busy, 0);
      chk("arst_mvalid", m_valid, 0);
      chk("arst_mdata", m_data, 0);
      chk("arst_cnt", sample_cnt, 0);
      chk("arst_ovf", err_overflow, 0);
      tick();
      rst = 1'b0;
      m_ready = 1'b1;
      tick();
      adc_data_in = 18'h12345;
      adc_data_in_valid = 1'b1;
      tick();
      adc_data_in_valid = 1'b0;
      tick();
      chk("post_rst_mvalid", m_valid, 0);
      chk("post_rst_cnt", sample_cnt, 0);
      chk("post_rst_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
